// File: rtl/rab_inval_walker.sv
// Range-invalidation walker: scans all L1 slices, then every L2 set/entry, clearing
// the valid bit of each entry whose page range overlaps the latched [start, end] range.
module rab_inval_walker #(
    parameter int AW            = 32,
    parameter int N_SLICES      = 32,
    parameter int N_SETS        = 32,
    parameter int N_SET_ENTRIES = 32,
    parameter int PG_OFFSET     = 12
) (
    input  logic                                            Clk_CI,
    input  logic                                            Rst_RI,
    input  logic                                            Start_SI,
    input  logic [AW-1:0]                                   AddrStart_DI,
    input  logic [AW-1:0]                                   AddrEnd_DI,
    output logic                                            Busy_SO,
    output logic                                            Done_SO,
    output logic [$clog2(N_SLICES)-1:0]                     SliceIdx_DO,
    input  logic [AW-1:0]                                   SliceFirst_DI,
    input  logic [AW-1:0]                                   SliceLast_DI,
    input  logic                                            SliceValid_SI,
    output logic                                            SliceClr_SO,
    output logic                                            L2Rd_SO,
    output logic [$clog2(N_SETS)+$clog2(N_SET_ENTRIES)-1:0] L2RdAddr_DO,
    input  logic [AW-PG_OFFSET-1:0]                         L2Vpn_DI,
    input  logic                                            L2Valid_SI,
    output logic                                            L2Clr_SO,
    output logic [$clog2(N_SETS)+$clog2(N_SET_ENTRIES)-1:0] L2ClrAddr_DO
);

    localparam int SLW  = $clog2(N_SLICES);
    localparam int SETW = $clog2(N_SETS);
    localparam int ENTW = $clog2(N_SET_ENTRIES);
    localparam int L2AW = SETW + ENTW;

    localparam logic [SLW-1:0]  SLICE_LAST = SLW'(N_SLICES - 1);
    localparam logic [SETW-1:0] SET_LAST   = SETW'(N_SETS - 1);
    localparam logic [ENTW-1:0] ENT_LAST   = ENTW'(N_SET_ENTRIES - 1);

    // states: IDLE wait start | L1_SCAN one slice/cycle | L2_SCAN one tag read/cycle
    //         | L2_DRAIN check last read | DONE one-cycle completion pulse
    typedef enum logic [2:0] {
        IDLE,
        L1_SCAN,
        L2_SCAN,
        L2_DRAIN,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     start_q, end_q;
    logic [SLW-1:0]    slice_q;
    logic [SETW-1:0]   set_q;
    logic [ENTW-1:0]   ent_q;
    logic              chk_q;
    logic [L2AW-1:0]   chk_addr_q;
    logic              slice_last;
    logic              l2_last;
    logic [AW-1:0]     page_lo, page_hi;

    assign slice_last = (slice_q == SLICE_LAST);
    assign l2_last    = (set_q == SET_LAST) && (ent_q == ENT_LAST);
    assign page_lo    = {L2Vpn_DI, {PG_OFFSET{1'b0}}};
    assign page_hi    = {L2Vpn_DI, {PG_OFFSET{1'b1}}};

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            state_q    <= IDLE;
            start_q    <= '0;
            end_q      <= '0;
            slice_q    <= '0;
            set_q      <= '0;
            ent_q      <= '0;
            chk_q      <= 1'b0;
            chk_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            // The tag returned next cycle belongs to this cycle's read address.
            chk_q      <= (state_q == L2_SCAN);
            chk_addr_q <= {set_q, ent_q};
            case (state_q)
                IDLE: begin
                    slice_q <= '0;
                    set_q   <= '0;
                    ent_q   <= '0;
                    if (Start_SI) begin
                        start_q <= AddrStart_DI;
                        end_q   <= AddrEnd_DI;
                    end
                end
                L1_SCAN: begin
                    if (slice_last) begin
                        slice_q <= '0;
                    end else begin
                        slice_q <= slice_q + 1'b1;
                    end
                end
                L2_SCAN: begin
                    if (ent_q == ENT_LAST) begin
                        ent_q <= '0;
                        if (set_q == SET_LAST) begin
                            set_q <= '0;
                        end else begin
                            set_q <= set_q + 1'b1;
                        end
                    end else begin
                        ent_q <= ent_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        Busy_SO     = 1'b0;
        Done_SO     = 1'b0;
        SliceClr_SO = 1'b0;
        L2Rd_SO     = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start_SI) begin
                    state_d = L1_SCAN;
                end
            end
            L1_SCAN: begin
                Busy_SO     = 1'b1;
                SliceClr_SO = SliceValid_SI && (SliceFirst_DI <= end_q) && (SliceLast_DI >= start_q);
                if (slice_last) begin
                    state_d = L2_SCAN;
                end
            end
            L2_SCAN: begin
                Busy_SO = 1'b1;
                L2Rd_SO = 1'b1;
                if (l2_last) begin
                    state_d = L2_DRAIN;
                end
            end
            L2_DRAIN: begin
                Busy_SO = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                Done_SO = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign SliceIdx_DO  = slice_q;
    assign L2RdAddr_DO  = {set_q, ent_q};
    assign L2Clr_SO     = chk_q && L2Valid_SI && (page_lo <= end_q) && (page_hi >= start_q);
    assign L2ClrAddr_DO = chk_q ? chk_addr_q : '0;

endmodule
